// File: rtl/fxp_pkg.sv
// fxp_pkg
// Shared definitions for the 20-bit sign-magnitude fixed-point format used by
// the neuron datapath lanes and the shared multiplier.
//   BITSIZE  : total word width (MSB is the sign bit)
//   FRAC_LSB : bit of the 38-bit magnitude product that lands on result bit 0
//   SAT_MSB  : lowest product bit that signals magnitude overflow
//   MAG_MAX  : saturated magnitude
//   fxp_t    : one sign-magnitude word (Q4.15 magnitude, 1.0 = 0x08000)
package fxp_pkg;

    localparam int          BITSIZE  = 20;
    localparam int          FRAC_LSB = 15;
    localparam int          SAT_MSB  = 34;
    localparam logic [18:0] MAG_MAX  = 19'h7FFFF;

    typedef logic [BITSIZE-1:0] fxp_t;

endpackage

// File: rtl/fixed_point_multiply.sv
// fixed_point_multiply
// Purely combinational sign-magnitude multiplier for fxp_t operands.
// Ports:
//   a, b : operands (sign in MSB, 19-bit Q4.15 magnitude)
//   y    : product, magnitude saturated to MAG_MAX on overflow
// Negative zero is not normalised: the sign is always sA ^ sB.
module fixed_point_multiply
    import fxp_pkg::*;
(
    input  fxp_t a,
    input  fxp_t b,
    output fxp_t y
);

    localparam int MAG_W  = BITSIZE - 1;
    localparam int PROD_W = 2 * MAG_W;

    logic [PROD_W-1:0] mag_a;
    logic [PROD_W-1:0] mag_b;
    logic [PROD_W-1:0] prod;
    logic [MAG_W-1:0]  mag;

    // Full-width magnitude product, then take the Q4.15 window or clamp when
    // any of the integer bits above the window are set.
    always_comb begin
        mag_a = {{MAG_W{1'b0}}, a[MAG_W-1:0]};
        mag_b = {{MAG_W{1'b0}}, b[MAG_W-1:0]};
        prod  = mag_a * mag_b;
        if (|prod[PROD_W-1:SAT_MSB]) begin
            mag = MAG_MAX;
        end else begin
            mag = prod[SAT_MSB-1:FRAC_LSB];
        end
        y = {a[BITSIZE-1] ^ b[BITSIZE-1], mag};
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter, reusable by any shared-resource scheduler.
// Ports:
//   valid : request vector, one bit per requester
//   ptr   : index where the search for a valid requester starts
//   grant : one-hot grant (all zero when nothing is valid)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    int   idx;
    logic found;

    // Walk the requesters starting at ptr and wrapping modulo N_REQ; the first
    // valid one wins. Modulo (not bit truncation) keeps non-power-of-two
    // requester counts correct.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fxp_mul_sched.sv
// fxp_mul_sched
// Shares one fixed_point_multiply among N_REQ lanes. Operand pairs are
// arbitrated round-robin, pass through two register stages (S1 operands,
// S2 product) and each product is returned to the lane that issued it.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready : per-lane request handshake
//   req_a, req_b        : per-lane operands, lane i at [i*BITSIZE +: BITSIZE]
//   rsp_valid           : one-hot, product available for that lane
//   rsp_ready           : per-lane accept; only the owning lane's bit matters
//   rsp_data, rsp_id    : shared product bus and its owner
//   busy                : any pipeline stage occupied
module fxp_mul_sched #(
    parameter int BITSIZE = 20,
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*BITSIZE-1:0] req_a,
    input  logic [N_REQ*BITSIZE-1:0] req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [BITSIZE-1:0]       rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               stall;
    logic               adv1;
    logic               adv2;

    logic               s1_v;
    logic [BITSIZE-1:0] s1_a;
    logic [BITSIZE-1:0] s1_b;
    logic [ID_W-1:0]    s1_id;

    logic               s2_v;
    logic [BITSIZE-1:0] s2_data;
    logic [ID_W-1:0]    s2_id;

    fxp_pkg::fxp_t      mul_y;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    fixed_point_multiply u_mul (
        .a (s1_a),
        .b (s1_b),
        .y (mul_y)
    );

    // Backpressure: S2 only holds when its own lane refuses the product, and
    // S1 may load whenever it is empty or S2 is moving. The grant is only
    // exposed as req_ready when S1 can actually take it.
    always_comb begin
        stall     = s2_v & ~rsp_ready[s2_id];
        adv2      = ~stall;
        adv1      = ~s1_v | adv2;
        req_ready = adv1 ? grant : '0;
        accept    = |req_ready;
        grant_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    // S1 captures the granted lane's operands; the round-robin pointer moves
    // past the winner so the same lane is found again only if nobody else asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            ptr   <= '0;
        end else if (adv1) begin
            s1_v <= accept;
            if (accept) begin
                s1_a  <= req_a[grant_id*BITSIZE +: BITSIZE];
                s1_b  <= req_b[grant_id*BITSIZE +: BITSIZE];
                s1_id <= grant_id;
                ptr   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // S2 registers the multiplier result together with its owner and holds
    // it until the owning lane accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_id   <= '0;
        end else if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= mul_y;
                s2_id   <= s1_id;
            end
        end
    end

    // Response bus is driven straight from S2, so there is no combinational
    // path from any req_* input to rsp_*.
    always_comb begin
        rsp_valid = s2_v ? (N_REQ'(1) << s2_id) : '0;
        rsp_data  = s2_data;
        rsp_id    = s2_id;
        busy      = s1_v | s2_v;
    end

endmodule
